// File: rtl/wd_pkg.sv
// Shared types and constants for the WD sector sequencer: state encoding, error codes,
// address-mark defaults and the CRC-16/CCITT step function.
package wd_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARM,
        S_SEARCH,
        S_ID,
        S_CHECK,
        S_DMARK,
        S_DATA,
        S_DCRC,
        S_DONE
    } state_e;

    localparam logic [2:0] ERR_OK        = 3'd0;
    localparam logic [2:0] ERR_NOT_FOUND = 3'd1;
    localparam logic [2:0] ERR_NO_DMARK  = 3'd2;
    localparam logic [2:0] ERR_ID_CRC    = 3'd3;
    localparam logic [2:0] ERR_DATA_CRC  = 3'd4;

    localparam logic [7:0]  ID_VAL_DEF   = 8'h1a;
    localparam logic [7:0]  DATA_VAL_DEF = 8'hf8;
    localparam logic [15:0] CRC_POLY     = 16'h1021;
    localparam logic [15:0] CRC_INIT     = 16'hffff;

    // MSB-first CRC-16/CCITT update over one byte.
    function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic [7:0] din);
        logic [15:0] r;
        r = crc ^ {din, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ((r << 1) ^ CRC_POLY) : (r << 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/wd_crc16.sv
// Byte-serial CRC-16/CCITT accumulator with synchronous clear; used by the sequencer
// only when WD_CRC_CHECK_EN is defined.
module wd_crc16
    import wd_pkg::*;
(
    input  logic        clk_50,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [15:0] crc
);

    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = CRC_INIT;
        end else if (en) begin
            crc_d = crc16_next(crc_q, din);
        end
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) crc_q <= CRC_INIT;
        else       crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/wd_sector_sequencer.sv
// Finds a target CHS sector in the decoded byte stream and streams its data bytes out.
// Optional CRC verification of ID and data fields is enabled by defining WD_CRC_CHECK_EN.
module wd_sector_sequencer
    import wd_pkg::*;
#(
    parameter logic [7:0] ID_VAL       = ID_VAL_DEF,
    parameter logic [7:0] DATA_VAL     = DATA_VAL_DEF,
    parameter int         SECTOR_BYTES = 512,
    parameter int         MAX_IDS      = 16,
    parameter int         MARK_WINDOW  = 32
) (
    input  logic        clk_50,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] target_cyl,
    input  logic [3:0]  target_head,
    input  logic [7:0]  target_sector,
    input  logic [7:0]  data_buffer,
    input  logic        data_valid,
    output logic        decoder_reset_n,
    output logic        busy,
    output logic [7:0]  sector_byte,
    output logic        sector_strobe,
    output logic [7:0]  id_flags,
    output logic        done,
    output logic [2:0]  error
);

    localparam int IDW = $clog2(MAX_IDS + 1);
    localparam int WW  = $clog2(MARK_WINDOW + 1);
`ifdef WD_CRC_CHECK_EN
    localparam logic [2:0] FLD_LAST = 3'd5;
`else
    localparam logic [2:0] FLD_LAST = 3'd3;
`endif

    state_e           state_q, state_d;
    logic             valid_prev_q;
    logic [11:0]      tcyl_q, tcyl_d;
    logic [3:0]       thead_q, thead_d;
    logic [7:0]       tsec_q, tsec_d;
    logic [IDW-1:0]   id_cnt_q, id_cnt_d;
    logic [2:0]       fld_q, fld_d;
    logic [7:0]       cyl_lo_q, cyl_lo_d;
    logic [7:0]       hi_head_q, hi_head_d;
    logic [7:0]       sec_q, sec_d;
    logic [7:0]       flags_q, flags_d;
    logic [WW-1:0]    win_q, win_d;
    logic [11:0]      byte_cnt_q, byte_cnt_d;
    logic [7:0]       sector_byte_q, sector_byte_d;
    logic             strobe_q, strobe_d;
    logic [7:0]       id_flags_q, id_flags_d;
    logic [2:0]       error_q, error_d;
    logic             take, id_match, id_last;

    // One take per byte window: previous cycle valid high, this cycle low.
    assign take     = valid_prev_q & ~data_valid;
    assign id_match = ({hi_head_q[7:4], cyl_lo_q} == tcyl_q) &&
                      (hi_head_q[3:0] == thead_q) && (sec_q == tsec_q);
    assign id_last  = (id_cnt_q >= IDW'(MAX_IDS - 1));

`ifdef WD_CRC_CHECK_EN
    logic [15:0] crc_val, crc_rx_q, crc_rx_d;
    logic        crc_clr, crc_en;

    assign crc_clr = (state_q == S_ARM) || (state_q == S_CHECK);
    assign crc_en  = take && (((state_q == S_SEARCH) && (data_buffer == ID_VAL)) ||
                              ((state_q == S_ID) && (fld_q < 3'd4)) ||
                              ((state_q == S_DMARK) && (data_buffer == DATA_VAL)) ||
                              (state_q == S_DATA));

    wd_crc16 u_crc (
        .clk_50 (clk_50),
        .reset  (reset),
        .clr    (crc_clr),
        .en     (crc_en),
        .din    (data_buffer),
        .crc    (crc_val)
    );
`endif

    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d       = state_q;
        tcyl_d        = tcyl_q;
        thead_d       = thead_q;
        tsec_d        = tsec_q;
        id_cnt_d      = id_cnt_q;
        fld_d         = fld_q;
        cyl_lo_d      = cyl_lo_q;
        hi_head_d     = hi_head_q;
        sec_d         = sec_q;
        flags_d       = flags_q;
        win_d         = win_q;
        byte_cnt_d    = byte_cnt_q;
        sector_byte_d = sector_byte_q;
        strobe_d      = 1'b0;
        id_flags_d    = id_flags_q;
        error_d       = error_q;
`ifdef WD_CRC_CHECK_EN
        crc_rx_d      = crc_rx_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tcyl_d   = target_cyl;
                    thead_d  = target_head;
                    tsec_d   = target_sector;
                    error_d  = ERR_OK;
                    id_cnt_d = '0;
                    state_d  = S_ARM;
                end
            end
            S_ARM: begin
                fld_d   = '0;
                state_d = S_SEARCH;
            end
            S_SEARCH: begin
                if (take) begin
                    if (data_buffer == ID_VAL) begin
                        state_d = S_ID;
                    end else if (id_last) begin
                        error_d = ERR_NOT_FOUND;
                        state_d = S_DONE;
                    end else begin
                        id_cnt_d = id_cnt_q + 1'b1;
                        state_d  = S_ARM;
                    end
                end
            end
            S_ID: begin
                if (take) begin
                    case (fld_q)
                        3'd0:    cyl_lo_d  = data_buffer;
                        3'd1:    hi_head_d = data_buffer;
                        3'd2:    sec_d     = data_buffer;
                        3'd3:    flags_d   = data_buffer;
`ifdef WD_CRC_CHECK_EN
                        default: crc_rx_d  = {crc_rx_q[7:0], data_buffer};
`else
                        default: ;
`endif
                    endcase
                    fld_d = fld_q + 1'b1;
                    if (fld_q == FLD_LAST) state_d = S_CHECK;
                end
            end
            S_CHECK: begin
`ifdef WD_CRC_CHECK_EN
                if (crc_rx_q != crc_val) begin
                    error_d = ERR_ID_CRC;
                    state_d = S_DONE;
                end else
`endif
                if (id_match) begin
                    id_flags_d = flags_q;
                    win_d      = '0;
                    state_d    = S_DMARK;
                end else if (id_last) begin
                    error_d = ERR_NOT_FOUND;
                    state_d = S_DONE;
                end else begin
                    id_cnt_d = id_cnt_q + 1'b1;
                    state_d  = S_ARM;
                end
            end
            S_DMARK: begin
                if (take) begin
                    if (data_buffer == DATA_VAL) begin
                        byte_cnt_d = '0;
                        state_d    = S_DATA;
                    end else if (win_q >= WW'(MARK_WINDOW - 1)) begin
                        error_d = ERR_NO_DMARK;
                        state_d = S_DONE;
                    end else begin
                        win_d = win_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (take) begin
                    sector_byte_d = data_buffer;
                    strobe_d      = 1'b1;
                    byte_cnt_d    = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == 12'(SECTOR_BYTES - 1)) begin
`ifdef WD_CRC_CHECK_EN
                        fld_d   = '0;
                        state_d = S_DCRC;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end
`ifdef WD_CRC_CHECK_EN
            S_DCRC: begin
                if (take) begin
                    crc_rx_d = {crc_rx_q[7:0], data_buffer};
                    fld_d    = fld_q + 1'b1;
                    if (fld_q == 3'd1) begin
                        if ({crc_rx_q[7:0], data_buffer} != crc_val) error_d = ERR_DATA_CRC;
                        state_d = S_DONE;
                    end
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            valid_prev_q  <= 1'b0;
            tcyl_q        <= '0;
            thead_q       <= '0;
            tsec_q        <= '0;
            id_cnt_q      <= '0;
            fld_q         <= '0;
            cyl_lo_q      <= '0;
            hi_head_q     <= '0;
            sec_q         <= '0;
            flags_q       <= '0;
            win_q         <= '0;
            byte_cnt_q    <= '0;
            sector_byte_q <= '0;
            strobe_q      <= 1'b0;
            id_flags_q    <= '0;
            error_q       <= ERR_OK;
`ifdef WD_CRC_CHECK_EN
            crc_rx_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            valid_prev_q  <= data_valid;
            tcyl_q        <= tcyl_d;
            thead_q       <= thead_d;
            tsec_q        <= tsec_d;
            id_cnt_q      <= id_cnt_d;
            fld_q         <= fld_d;
            cyl_lo_q      <= cyl_lo_d;
            hi_head_q     <= hi_head_d;
            sec_q         <= sec_d;
            flags_q       <= flags_d;
            win_q         <= win_d;
            byte_cnt_q    <= byte_cnt_d;
            sector_byte_q <= sector_byte_d;
            strobe_q      <= strobe_d;
            id_flags_q    <= id_flags_d;
            error_q       <= error_d;
`ifdef WD_CRC_CHECK_EN
            crc_rx_q      <= crc_rx_d;
`endif
        end
    end

    assign decoder_reset_n = (state_q != S_ARM);
    assign busy            = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done            = (state_q == S_DONE);
    assign sector_byte     = sector_byte_q;
    assign sector_strobe   = strobe_q;
    assign id_flags        = id_flags_q;
    assign error           = error_q;

endmodule

// File: tb/tb_wd_sector_sequencer.sv
// Directed self-checking bench for wd_sector_sequencer in its default build
// (WD_CRC_CHECK_EN undefined): match, retry, not-found, no-data-mark and mid-command reset.
module tb_wd_sector_sequencer;

    logic        clk_50 = 1'b0;
    logic        reset  = 1'b1;
    logic        start  = 1'b0;
    logic [11:0] target_cyl    = '0;
    logic [3:0]  target_head   = '0;
    logic [7:0]  target_sector = '0;
    logic [7:0]  data_buffer   = '0;
    logic        data_valid    = 1'b1;
    logic        decoder_reset_n, busy, sector_strobe, done;
    logic [7:0]  sector_byte, id_flags;
    logic [2:0]  error;

    wd_sector_sequencer dut (
        .clk_50          (clk_50),
        .reset           (reset),
        .start           (start),
        .target_cyl      (target_cyl),
        .target_head     (target_head),
        .target_sector   (target_sector),
        .data_buffer     (data_buffer),
        .data_valid      (data_valid),
        .decoder_reset_n (decoder_reset_n),
        .busy            (busy),
        .sector_byte     (sector_byte),
        .sector_strobe   (sector_strobe),
        .id_flags        (id_flags),
        .done            (done),
        .error           (error)
    );

    always #10 clk_50 = ~clk_50;

    int         total = 0;
    int         bad   = 0;
    int         strobe_cnt = 0;
    int         done_cnt   = 0;
    int         arm_cnt    = 0;
    logic [2:0] done_err   = '0;
    logic [7:0] log_mem [0:4095];

    // Observer: records strobed bytes, done pulses and decoder re-arm pulses.
    always @(negedge clk_50) begin
        if (sector_strobe) begin
            if (strobe_cnt < 4096) log_mem[strobe_cnt] = sector_byte;
            strobe_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_err = error;
        end
        if (!decoder_reset_n) arm_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_50);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        data_buffer = b;
        data_valid  = 1'b0;
        tick();
        tick();
        data_valid  = 1'b1;
        tick();
        tick();
    endtask

    task automatic send_id(input logic [7:0] cl, input logic [7:0] hh,
                           input logic [7:0] s,  input logic [7:0] f);
        send_byte(8'h1a);
        send_byte(cl);
        send_byte(hh);
        send_byte(s);
        send_byte(f);
    endtask

    task automatic do_start(input logic [11:0] c, input logic [3:0] h, input logic [7:0] s);
        target_cyl    = c;
        target_head   = h;
        target_sector = s;
        start         = 1'b1;
        tick();
        start         = 1'b0;
        tick();
    endtask

    task automatic send_data(input int n);
        for (int i = 0; i < n; i++) send_byte(i[7:0]);
    endtask

    task automatic wait_done(input string tag, input int base);
        for (int i = 0; i < 20 && done_cnt == base; i++) tick();
        check(tag, done_cnt - base, 1);
    endtask

    task automatic check_order(input string tag, input int base, input int n);
        int mism;
        mism = 0;
        for (int i = 0; i < n; i++) begin
            if (log_mem[base + i] !== i[7:0]) mism++;
        end
        check(tag, mism, 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"},   busy, 0);
        check({tag, "_dresn"},  decoder_reset_n, 1);
        check({tag, "_sbyte"},  sector_byte, 0);
        check({tag, "_strobe"}, sector_strobe, 0);
        check({tag, "_flags"},  id_flags, 0);
        check({tag, "_done"},   done, 0);
        check({tag, "_error"},  error, 0);
    endtask

    int sb, ab, db;

    initial begin
        // Reset state
        repeat (3) tick();
        check_reset_state("rst");
        reset = 1'b0;
        tick();

        // Test 1: direct match, 512 bytes streamed in order; a start while busy is ignored
        sb = strobe_cnt; ab = arm_cnt; db = done_cnt;
        do_start(12'd5, 4'd2, 8'd7);
        check("t1_busy", busy, 1);
        check("t1_arm_once", arm_cnt - ab, 1);
        send_id(8'h05, 8'h02, 8'h07, 8'h00);
        send_byte(8'hf8);
        target_sector = 8'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t1_busy_start_ignored", arm_cnt - ab, 1);
        send_data(512);
        wait_done("t1_done", db);
        check("t1_strobes", strobe_cnt - sb, 512);
        check_order("t1_order", sb, 512);
        check("t1_error", done_err, 0);
        check("t1_flags", id_flags, 8'h00);
        check("t1_idle", busy, 0);

        // Test 2: first ID wrong sector -> re-arm, second matches
        sb = strobe_cnt; ab = arm_cnt; db = done_cnt;
        do_start(12'd5, 4'd2, 8'd7);
        send_id(8'h05, 8'h02, 8'h06, 8'h00);
        check("t2_rearm", arm_cnt - ab, 2);
        check("t2_no_done", done_cnt - db, 0);
        send_id(8'h05, 8'h02, 8'h07, 8'h5a);
        check("t2_flags", id_flags, 8'h5a);
        send_byte(8'hf8);
        send_data(512);
        wait_done("t2_done", db);
        check("t2_strobes", strobe_cnt - sb, 512);
        check_order("t2_order", sb, 512);
        check("t2_error", done_err, 0);
        check("t2_arm_total", arm_cnt - ab, 2);

        // Test 3: 16 non-matching IDs -> NOT_FOUND
        sb = strobe_cnt; ab = arm_cnt; db = done_cnt;
        do_start(12'd5, 4'd2, 8'd7);
        for (int i = 0; i < 15; i++) send_id(8'h05, 8'h02, 8'h06, 8'h00);
        check("t3_busy_after_15", busy, 1);
        check("t3_no_done_15", done_cnt - db, 0);
        send_id(8'h05, 8'h02, 8'h06, 8'h00);
        wait_done("t3_done", db);
        check("t3_error", done_err, 1);
        check("t3_error_held", error, 1);
        check("t3_strobes", strobe_cnt - sb, 0);
        check("t3_arms", arm_cnt - ab, 16);

        // Test 4: full 12-bit cylinder compare, then no data mark within 32 takes
        sb = strobe_cnt; ab = arm_cnt; db = done_cnt;
        do_start(12'h305, 4'd9, 8'd3);
        check("t4_error_cleared", error, 0);
        send_id(8'h05, 8'h09, 8'h03, 8'h00);
        check("t4_cyl_hi_mismatch", arm_cnt - ab, 2);
        send_id(8'h05, 8'h39, 8'h03, 8'hc3);
        check("t4_flags", id_flags, 8'hc3);
        for (int i = 0; i < 31; i++) send_byte(8'h4e);
        check("t4_no_done_31", done_cnt - db, 0);
        send_byte(8'h4e);
        wait_done("t4_done", db);
        check("t4_error", done_err, 2);
        check("t4_strobes", strobe_cnt - sb, 0);

        // Test 5: reset in the middle of the data field, then a clean command
        db = done_cnt;
        do_start(12'd5, 4'd2, 8'd7);
        send_id(8'h05, 8'h02, 8'h07, 8'h77);
        send_byte(8'hf8);
        send_data(100);
        check("t5_busy_mid", busy, 1);
        reset = 1'b1;
        tick();
        check_reset_state("t5_rst");
        reset = 1'b0;
        repeat (4) tick();
        check("t5_no_done", done_cnt - db, 0);
        sb = strobe_cnt; db = done_cnt;
        do_start(12'd5, 4'd2, 8'd7);
        send_id(8'h05, 8'h02, 8'h07, 8'h11);
        send_byte(8'hf8);
        send_data(512);
        wait_done("t5_done", db);
        check("t5_strobes", strobe_cnt - sb, 512);
        check_order("t5_order", sb, 512);
        check("t5_error", done_err, 0);
        check("t5_flags", id_flags, 8'h11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
